// File: rtl/sonuc_toplayici_pkg.sv
// Shared constants for the result collector: default FIFO geometry and the
// width/saturation point of the statistics counters.
package sonuc_toplayici_pkg;

    localparam int GENISLIK_VARSAYILAN = 8;
    localparam int DERINLIK_VARSAYILAN = 4;

    localparam int                        SAYAC_GENISLIK = 8;
    localparam logic [SAYAC_GENISLIK-1:0] SAYAC_DOYUM    = 8'hFF;

endpackage

// File: rtl/sonuc_bellek.sv
// DERINLIK x GENISLIK register array: one synchronous write port and one
// combinational read port, used as FIFO storage by sonuc_toplayici.
module sonuc_bellek
    import sonuc_toplayici_pkg::*;
#(
    parameter int GENISLIK = GENISLIK_VARSAYILAN,
    parameter int DERINLIK = DERINLIK_VARSAYILAN,
    parameter int ADRES    = $clog2(DERINLIK)
) (
    input  logic                saat,
    input  logic                yaz_en,
    input  logic [ADRES-1:0]    yaz_adr,
    input  logic [GENISLIK-1:0] yaz_veri,
    input  logic [ADRES-1:0]    oku_adr,
    output logic [GENISLIK-1:0] oku_veri
);

    logic [GENISLIK-1:0] bellek_q [DERINLIK];
    logic [GENISLIK-1:0] bellek_d [DERINLIK];

    always_comb begin
        bellek_d = bellek_q;
        if (yaz_en) begin
            bellek_d[yaz_adr] = yaz_veri;
        end
    end

    // Storage is data only; validity is tracked by the owner's pointers, so no reset.
    always_ff @(posedge saat) begin
        bellek_q <= bellek_d;
    end

    assign oku_veri = bellek_q[oku_adr];

endmodule

// File: rtl/sonuc_toplayici.sv
// Result collector: buffers each finished result in a small show-ahead FIFO,
// hands it to a valid/ready consumer and keeps accept/drop/min/max statistics.
module sonuc_toplayici
    import sonuc_toplayici_pkg::*;
#(
    parameter int GENISLIK = GENISLIK_VARSAYILAN,
    parameter int DERINLIK = DERINLIK_VARSAYILAN,
    parameter int ADRES    = $clog2(DERINLIK)
) (
    input  logic                      saat,
    input  logic                      reset,
    input  logic                      giris_gecerli,
    input  logic [GENISLIK-1:0]       giris_veri,
    output logic [GENISLIK-1:0]       cikis_veri,
    output logic                      cikis_gecerli,
    input  logic                      cikis_hazir,
    output logic [ADRES:0]            doluluk,
    output logic                      dolu,
    output logic                      kayip,
    output logic [SAYAC_GENISLIK-1:0] kabul_sayisi,
    output logic [SAYAC_GENISLIK-1:0] kayip_sayisi,
    output logic [GENISLIK-1:0]       en_buyuk,
    output logic [GENISLIK-1:0]       en_kucuk
);

    function automatic logic [SAYAC_GENISLIK-1:0] doygun_artir(
        input logic [SAYAC_GENISLIK-1:0] deger
    );
        return (deger == SAYAC_DOYUM) ? deger : deger + SAYAC_GENISLIK'(1);
    endfunction

    logic [ADRES-1:0]          wr_ptr_q, wr_ptr_d;
    logic [ADRES-1:0]          rd_ptr_q, rd_ptr_d;
    logic [ADRES:0]            doluluk_q, doluluk_d;
    logic                      kayip_q, kayip_d;
    logic [SAYAC_GENISLIK-1:0] kabul_sayisi_q, kabul_sayisi_d;
    logic [SAYAC_GENISLIK-1:0] kayip_sayisi_q, kayip_sayisi_d;
    logic [GENISLIK-1:0]       en_buyuk_q, en_buyuk_d;
    logic [GENISLIK-1:0]       en_kucuk_q, en_kucuk_d;

    logic                      pop, push, drop;
    logic [GENISLIK-1:0]       bas_veri;

    assign cikis_gecerli = (doluluk_q != '0);
    assign dolu          = (doluluk_q == (ADRES+1)'(DERINLIK));

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign pop  = cikis_gecerli & cikis_hazir;
    assign push = giris_gecerli & (~dolu | pop);
    assign drop = giris_gecerli & dolu & ~pop;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        doluluk_d      = doluluk_q;
        kabul_sayisi_d = kabul_sayisi_q;
        kayip_sayisi_d = kayip_sayisi_q;
        en_buyuk_d     = en_buyuk_q;
        en_kucuk_d     = en_kucuk_q;
        kayip_d        = drop;

        if (push) begin
            wr_ptr_d       = wr_ptr_q + ADRES'(1);
            kabul_sayisi_d = doygun_artir(kabul_sayisi_q);
            if (giris_veri > en_buyuk_q) en_buyuk_d = giris_veri;
            if (giris_veri < en_kucuk_q) en_kucuk_d = giris_veri;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADRES'(1);
        end
        if (drop) begin
            kayip_sayisi_d = doygun_artir(kayip_sayisi_q);
        end

        case ({push, pop})
            2'b10:   doluluk_d = doluluk_q + (ADRES+1)'(1);
            2'b01:   doluluk_d = doluluk_q - (ADRES+1)'(1);
            default: doluluk_d = doluluk_q;
        endcase
    end

    always_ff @(posedge saat) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            doluluk_q      <= '0;
            kayip_q        <= 1'b0;
            kabul_sayisi_q <= '0;
            kayip_sayisi_q <= '0;
            en_buyuk_q     <= '0;
            en_kucuk_q     <= '1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            doluluk_q      <= doluluk_d;
            kayip_q        <= kayip_d;
            kabul_sayisi_q <= kabul_sayisi_d;
            kayip_sayisi_q <= kayip_sayisi_d;
            en_buyuk_q     <= en_buyuk_d;
            en_kucuk_q     <= en_kucuk_d;
        end
    end

    sonuc_bellek #(
        .GENISLIK (GENISLIK),
        .DERINLIK (DERINLIK),
        .ADRES    (ADRES)
    ) u_bellek (
        .saat     (saat),
        .yaz_en   (push),
        .yaz_adr  (wr_ptr_q),
        .yaz_veri (giris_veri),
        .oku_adr  (rd_ptr_q),
        .oku_veri (bas_veri)
    );

    // Masking the stale array contents keeps pre-reset data off the output.
    assign cikis_veri   = cikis_gecerli ? bas_veri : '0;
    assign doluluk      = doluluk_q;
    assign kayip        = kayip_q;
    assign kabul_sayisi = kabul_sayisi_q;
    assign kayip_sayisi = kayip_sayisi_q;
    assign en_buyuk     = en_buyuk_q;
    assign en_kucuk     = en_kucuk_q;

endmodule

// File: tb/tb_sonuc_toplayici.sv
// Bench for sonuc_toplayici: directed vector table, a streaming sequence and
// a long random run checked against a queue-based model.
module tb_sonuc_toplayici;

    logic       saat = 1'b0;
    logic       reset;
    logic       giris_gecerli;
    logic [7:0] giris_veri;
    logic [7:0] cikis_veri;
    logic       cikis_gecerli;
    logic       cikis_hazir;
    logic [2:0] doluluk;
    logic       dolu;
    logic       kayip;
    logic [7:0] kabul_sayisi;
    logic [7:0] kayip_sayisi;
    logic [7:0] en_buyuk;
    logic [7:0] en_kucuk;

    always #5 saat = ~saat;

    sonuc_toplayici #(.GENISLIK(8), .DERINLIK(4), .ADRES(2)) dut (
        .saat          (saat),
        .reset         (reset),
        .giris_gecerli (giris_gecerli),
        .giris_veri    (giris_veri),
        .cikis_veri    (cikis_veri),
        .cikis_gecerli (cikis_gecerli),
        .cikis_hazir   (cikis_hazir),
        .doluluk       (doluluk),
        .dolu          (dolu),
        .kayip         (kayip),
        .kabul_sayisi  (kabul_sayisi),
        .kayip_sayisi  (kayip_sayisi),
        .en_buyuk      (en_buyuk),
        .en_kucuk      (en_kucuk)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: a plain queue plus counters
    logic [7:0] mq[$];
    int         m_kabul, m_kks;
    logic [7:0] m_max, m_min;
    bit         m_kayip;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r_st, input bit v, input logic [7:0] d, input bit rdy);
        bit pop, acc;
        reset = r_st; giris_gecerli = v; giris_veri = d; cikis_hazir = rdy;
        @(posedge saat);
        if (r_st) begin
            mq.delete();
            m_kabul = 0; m_kks = 0; m_max = 8'h00; m_min = 8'hFF; m_kayip = 0;
        end else begin
            pop = (mq.size() > 0) && rdy;
            acc = v && ((mq.size() < 4) || pop);
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(d);
                if (m_kabul < 255) m_kabul++;
                if (d > m_max) m_max = d;
                if (d < m_min) m_min = d;
            end
            m_kayip = v && !acc;
            if (m_kayip && m_kks < 255) m_kks++;
        end
        #1;
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".gecerli"}, cikis_gecerli, mq.size() > 0);
        chk({nm, ".veri"},    cikis_veri, (mq.size() > 0) ? mq[0] : 8'h00);
        chk({nm, ".doluluk"}, doluluk, mq.size());
        chk({nm, ".dolu"},    dolu, mq.size() == 4);
        chk({nm, ".kayip"},   kayip, m_kayip);
        chk({nm, ".kabul"},   kabul_sayisi, m_kabul);
        chk({nm, ".kks"},     kayip_sayisi, m_kks);
        chk({nm, ".max"},     en_buyuk, m_max);
        chk({nm, ".min"},     en_kucuk, m_min);
    endtask

    typedef struct {
        bit         rst;
        bit         v;
        logic [7:0] d;
        bit         r;
        bit         e_gec;
        logic [7:0] e_veri;
        int         e_dol;
        bit         e_kay;
        int         e_kab;
        int         e_kks;
        logic [7:0] e_max;
        logic [7:0] e_min;
    } vek_t;

    vek_t tablo[$];

    initial begin
        //                  rst v  d      r  gec veri   dol kay kab kks max    min
        tablo.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF});
        tablo.push_back('{0, 1, 8'h05, 0, 1, 8'h05, 1, 0, 1, 0, 8'h05, 8'h05});
        tablo.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 8'h05, 8'h05});
        tablo.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF});
        tablo.push_back('{0, 1, 8'h10, 0, 1, 8'h10, 1, 0, 1, 0, 8'h10, 8'h10});
        tablo.push_back('{0, 1, 8'h03, 0, 1, 8'h10, 2, 0, 2, 0, 8'h10, 8'h03});
        tablo.push_back('{0, 1, 8'hF0, 0, 1, 8'h10, 3, 0, 3, 0, 8'hF0, 8'h03});
        tablo.push_back('{0, 1, 8'h07, 0, 1, 8'h10, 4, 0, 4, 0, 8'hF0, 8'h03});
        tablo.push_back('{0, 1, 8'h99, 0, 1, 8'h10, 4, 1, 4, 1, 8'hF0, 8'h03});
        tablo.push_back('{0, 0, 8'h00, 0, 1, 8'h10, 4, 0, 4, 1, 8'hF0, 8'h03});
        tablo.push_back('{0, 1, 8'h22, 1, 1, 8'h03, 4, 0, 5, 1, 8'hF0, 8'h03});
        tablo.push_back('{0, 0, 8'h00, 1, 1, 8'hF0, 3, 0, 5, 1, 8'hF0, 8'h03});
        tablo.push_back('{0, 0, 8'h00, 1, 1, 8'h07, 2, 0, 5, 1, 8'hF0, 8'h03});
        tablo.push_back('{0, 0, 8'h00, 1, 1, 8'h22, 1, 0, 5, 1, 8'hF0, 8'h03});
        tablo.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 5, 1, 8'hF0, 8'h03});
        tablo.push_back('{0, 1, 8'hAA, 0, 1, 8'hAA, 1, 0, 6, 1, 8'hF0, 8'h03});
        tablo.push_back('{0, 1, 8'hBB, 0, 1, 8'hAA, 2, 0, 7, 1, 8'hF0, 8'h03});
        tablo.push_back('{0, 1, 8'hCC, 0, 1, 8'hAA, 3, 0, 8, 1, 8'hF0, 8'h03});
        tablo.push_back('{1, 1, 8'hDD, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF});
        tablo.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF});

        reset = 1'b1; giris_gecerli = 1'b0; giris_veri = 8'h00; cikis_hazir = 1'b0;
        @(negedge saat);

        foreach (tablo[i]) begin
            step(tablo[i].rst, tablo[i].v, tablo[i].d, tablo[i].r);
            chk($sformatf("tab%0d.gecerli", i), cikis_gecerli, tablo[i].e_gec);
            chk($sformatf("tab%0d.veri", i),    cikis_veri,    tablo[i].e_veri);
            chk($sformatf("tab%0d.doluluk", i), doluluk,       tablo[i].e_dol);
            chk($sformatf("tab%0d.dolu", i),    dolu,          tablo[i].e_dol == 4);
            chk($sformatf("tab%0d.kayip", i),   kayip,         tablo[i].e_kay);
            chk($sformatf("tab%0d.kabul", i),   kabul_sayisi,  tablo[i].e_kab);
            chk($sformatf("tab%0d.kks", i),     kayip_sayisi,  tablo[i].e_kks);
            chk($sformatf("tab%0d.max", i),     en_buyuk,      tablo[i].e_max);
            chk($sformatf("tab%0d.min", i),     en_kucuk,      tablo[i].e_min);
        end

        // Streaming with the consumer always ready: each push is visible next cycle
        for (int i = 0; i < 10; i++) begin
            logic [7:0] dv;
            dv = 8'(8'h40 + i * 3);
            step(0, 1, dv, 1);
            chk($sformatf("akis%0d.veri", i),    cikis_veri, dv);
            chk($sformatf("akis%0d.gecerli", i), cikis_gecerli, 1'b1);
            chk($sformatf("akis%0d.doluluk", i), doluluk, 3'd1);
            chk($sformatf("akis%0d.kayip", i),   kayip, 1'b0);
        end
        step(0, 0, 8'h00, 1);
        chk("akis_son.doluluk", doluluk, 3'd0);
        chk("akis_son.kabul",   kabul_sayisi, 8'd10);

        // Random: first a congested phase to drive both counters into saturation
        for (int i = 0; i < 1500; i++) begin
            step(0, $urandom_range(0, 9) != 0, 8'($urandom), $urandom_range(0, 4) == 0);
            chk_model($sformatf("sik%0d", i));
        end
        chk("doyum.kabul", kabul_sayisi, 8'hFF);
        chk("doyum.kks",   kayip_sayisi, 8'hFF);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1), 8'($urandom),
                 $urandom_range(0, 1));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
